// File: rtl/elev_pkg.sv
// Shared elevator types, floor/direction constants and hall-latch index helpers
// used by the car motion controller.
package elev_pkg;

    localparam logic [2:0] FLOOR_MIN = 3'd1;
    localparam logic [2:0] FLOOR_MAX = 3'd6;
    localparam logic       DIR_UP    = 1'b0;
    localparam logic       DIR_DN    = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_e;

    function automatic logic [3:0] hall_up_idx(input logic [2:0] f);
        return {f, 1'b0} - 4'd2;
    endfunction

    function automatic logic [3:0] hall_dn_idx(input logic [2:0] f);
        return {f, 1'b0} - 4'd3;
    endfunction

    function automatic logic floor_valid(input logic [2:0] f);
        return (f >= FLOOR_MIN) && (f <= FLOOR_MAX);
    endfunction

    function automatic logic [5:0] floor_onehot(input logic [2:0] f);
        return 6'd1 << (f - 3'd1);
    endfunction

    // Terminal floors own a single hall button, so they are cleared regardless of direction.
    function automatic logic [9:0] hall_clear(input logic [2:0] f, input logic dir, input logic both);
        logic [9:0] m;
        m = 10'd0;
        if ((both || (dir == DIR_UP)) && (f < FLOOR_MAX)) m[hall_up_idx(f)] = 1'b1;
        else m = m;
        if ((both || (dir == DIR_DN)) && (f > FLOOR_MIN)) m[hall_dn_idx(f)] = 1'b1;
        else m = m;
        if (f == FLOOR_MAX) m[9] = 1'b1;
        else m = m;
        if (f == FLOOR_MIN) m[0] = 1'b1;
        else m = m;
        return m;
    endfunction

endpackage

// File: rtl/elev_tick_timer.sv
// Down-counting interval timer: load arms it for N cycles, done flags the last
// enabled cycle of the interval.
module elev_tick_timer #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam logic [W-1:0] RELOAD = W'(N - 1);
    localparam logic [W-1:0] ZERO   = {W{1'b0}};
    localparam logic [W-1:0] ONE    = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_r;

    // Counter register: load wins over counting, and it parks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= ZERO;
        end else if (load) begin
            count_r <= RELOAD;
        end else if (en && (count_r != ZERO)) begin
            count_r <= count_r - ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign done = en && (count_r == ZERO);

endmodule

// File: rtl/car_motion_ctrl.sv
// Car motion sequencer: moves floor by floor toward the computed destination,
// opens the door and strobes request-latch clears. Optional CAR_ESTOP_EN adds an estop freeze.
module car_motion_ctrl
    import elev_pkg::*;
#(
    parameter int FLOOR_TICKS = 8,
    parameter int DOOR_TICKS  = 6
) (
    input  logic       input_clk,
    input  logic       input_rst,
    input  logic [2:0] input_des,
    input  logic       input_bool,
    input  logic       input_hold,
`ifdef CAR_ESTOP_EN
    input  logic       input_estop,
    output logic       output_fault,
`endif
    output logic [2:0] output_now,
    output logic       output_dir,
    output logic       output_moving,
    output logic       output_door_open,
    output logic       output_arrive,
    output logic [5:0] output_clr_in,
    output logic [9:0] output_clr_out
);

    localparam int TMAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int TW   = $clog2(TMAX) + 1;

    state_e     state_r, state_nx_s;
    logic [2:0] floor_r, floor_nx_s, step_s;
    logic       dir_r, dir_nx_s;
    logic       moving_r, door_open_r, arrive_r, arrive_nx_s;
    logic [5:0] clr_in_r, clr_in_nx_s;
    logic [9:0] clr_out_r, clr_out_nx_s;
    logic       floor_load_s, floor_en_s, floor_done_s;
    logic       door_load_s, door_en_s, door_done_s;
    logic       freeze_s, req_ok_s, at_end_s, behind_s;

`ifdef CAR_ESTOP_EN
    logic fault_r;
    assign freeze_s     = input_estop;
    assign output_fault = fault_r;
`else
    assign freeze_s = 1'b0;
`endif

    assign req_ok_s   = input_bool && floor_valid(input_des);
    assign step_s     = (dir_r == DIR_UP) ? (floor_r + 3'd1) : (floor_r - 3'd1);
    assign at_end_s   = (dir_r == DIR_UP) ? (floor_r == FLOOR_MAX) : (floor_r == FLOOR_MIN);
    assign behind_s   = (dir_r == DIR_UP) ? (input_des < step_s) : (input_des > step_s);
    assign floor_en_s = (state_r == MOVE) && !freeze_s;
    assign door_en_s  = (state_r == DOOR) && !freeze_s;

    elev_tick_timer #(.N(FLOOR_TICKS), .W(TW)) u_floor_timer (
        .clk  (input_clk),
        .rst  (input_rst),
        .load (floor_load_s),
        .en   (floor_en_s),
        .done (floor_done_s)
    );

    elev_tick_timer #(.N(DOOR_TICKS), .W(TW)) u_door_timer (
        .clk  (input_clk),
        .rst  (input_rst),
        .load (door_load_s),
        .en   (door_en_s),
        .done (door_done_s)
    );

    // Next-state, floor/direction update, timer loads and entry strobes.
    always_comb begin
        state_nx_s   = state_r;
        floor_nx_s   = floor_r;
        dir_nx_s     = dir_r;
        arrive_nx_s  = 1'b0;
        clr_in_nx_s  = 6'd0;
        clr_out_nx_s = 10'd0;
        floor_load_s = 1'b0;
        door_load_s  = 1'b0;
        if (freeze_s) begin
            state_nx_s = state_r;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!req_ok_s) begin
                        state_nx_s = IDLE;
                    end else if (input_des > floor_r) begin
                        dir_nx_s     = DIR_UP;
                        state_nx_s   = MOVE;
                        floor_load_s = 1'b1;
                    end else if (input_des < floor_r) begin
                        dir_nx_s     = DIR_DN;
                        state_nx_s   = MOVE;
                        floor_load_s = 1'b1;
                    end else begin
                        state_nx_s   = DOOR;
                        door_load_s  = 1'b1;
                        arrive_nx_s  = 1'b1;
                        clr_in_nx_s  = floor_onehot(floor_r);
                        clr_out_nx_s = hall_clear(floor_r, dir_r, 1'b1);
                    end
                end
                MOVE: begin
                    if (!floor_done_s) begin
                        state_nx_s = MOVE;
                    end else if (at_end_s) begin
                        state_nx_s = IDLE;
                    end else begin
                        // The destination is re-read live at every floor boundary.
                        floor_nx_s = step_s;
                        if (req_ok_s && (input_des == step_s)) begin
                            state_nx_s   = DOOR;
                            door_load_s  = 1'b1;
                            arrive_nx_s  = 1'b1;
                            clr_in_nx_s  = floor_onehot(step_s);
                            clr_out_nx_s = hall_clear(step_s, dir_r, 1'b0);
                        end else if (!req_ok_s || behind_s) begin
                            state_nx_s = IDLE;
                        end else begin
                            state_nx_s   = MOVE;
                            floor_load_s = 1'b1;
                        end
                    end
                end
                DOOR: begin
                    if (input_hold) begin
                        door_load_s = 1'b1;
                    end else if (door_done_s) begin
                        state_nx_s = IDLE;
                    end else begin
                        state_nx_s = DOOR;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge input_clk) begin
        if (input_rst) begin
            state_r     <= IDLE;
            floor_r     <= FLOOR_MIN;
            dir_r       <= DIR_UP;
            moving_r    <= 1'b0;
            door_open_r <= 1'b0;
            arrive_r    <= 1'b0;
            clr_in_r    <= 6'd0;
            clr_out_r   <= 10'd0;
        end else begin
            state_r     <= state_nx_s;
            floor_r     <= floor_nx_s;
            dir_r       <= dir_nx_s;
            moving_r    <= (state_nx_s == MOVE);
            door_open_r <= (state_nx_s == DOOR);
            arrive_r    <= arrive_nx_s;
            clr_in_r    <= clr_in_nx_s;
            clr_out_r   <= clr_out_nx_s;
        end
    end

`ifdef CAR_ESTOP_EN
    // Fault flag mirrors the sampled estop input.
    always_ff @(posedge input_clk) begin
        if (input_rst) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= input_estop;
        end
    end
`endif

    assign output_now       = floor_r;
    assign output_dir       = dir_r;
    assign output_moving    = moving_r;
    assign output_door_open = door_open_r;
    assign output_arrive    = arrive_r;
    assign output_clr_in    = clr_in_r;
    assign output_clr_out   = clr_out_r;

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Scenario bench for car_motion_ctrl (FLOOR_TICKS=4, DOOR_TICKS=3): expected output
// vectors are queued per cycle as stimulus is applied and compared as cycles complete.
module tb_car_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] des;
    logic       req;
    logic       hold;
    logic [2:0] now;
    logic       dir, moving, door_open, arrive;
    logic [5:0] clr_in;
    logic [9:0] clr_out;
`ifdef CAR_ESTOP_EN
    logic       estop;
    logic       fault;
`endif

    logic [22:0] exp_q[$];
    logic [22:0] got, want;
    int checks = 0;
    int errors = 0;

    car_motion_ctrl #(.FLOOR_TICKS(4), .DOOR_TICKS(3)) dut (
        .input_clk        (clk),
        .input_rst        (rst),
        .input_des        (des),
        .input_bool       (req),
        .input_hold       (hold),
`ifdef CAR_ESTOP_EN
        .input_estop      (estop),
        .output_fault     (fault),
`endif
        .output_now       (now),
        .output_dir       (dir),
        .output_moving    (moving),
        .output_door_open (door_open),
        .output_arrive    (arrive),
        .output_clr_in    (clr_in),
        .output_clr_out   (clr_out)
    );

    always #5 clk = ~clk;

    // Vector order: now, dir, moving, door_open, arrive, clr_in, clr_out
    function automatic logic [22:0] ev(input logic [2:0] n, input logic d, input logic mv,
                                       input logic dr, input logic ar,
                                       input logic [5:0] ci, input logic [9:0] co);
        return {n, d, mv, dr, ar, ci, co};
    endfunction

    function automatic logic [22:0] obs();
        return {now, dir, moving, door_open, arrive, clr_in, clr_out};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; des = 3'd0; req = 1'b0; hold = 1'b0;
        for (int c = 1; c <= 2; c++) exp_q.push_back(ev(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 10'd0));
        for (int c = 1; c <= 2; c++) begin
            tick();
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset c%0d: got %b want %b", c, got, want);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_move_up();
        des = 3'd3; req = 1'b1;
        for (int c = 1; c <= 4; c++) exp_q.push_back(ev(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 10'd0));
        for (int c = 5; c <= 8; c++) exp_q.push_back(ev(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 10'd0));
        exp_q.push_back(ev(3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000100, 10'b0000010000));
        for (int c = 10; c <= 11; c++) exp_q.push_back(ev(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 10'd0));
        exp_q.push_back(ev(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 10'd0));
        for (int c = 1; c <= 12; c++) begin
            tick();
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL move_up c%0d: got %b want %b", c, got, want);
            end
            if (c == 11) req = 1'b0;
        end
    endtask

    task automatic test_door_here();
        des = 3'd3; req = 1'b1;
        exp_q.push_back(ev(3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000100, 10'b0000011000));
        for (int c = 2; c <= 3; c++) exp_q.push_back(ev(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 10'd0));
        exp_q.push_back(ev(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 10'd0));
        for (int c = 1; c <= 4; c++) begin
            tick();
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL door_here c%0d: got %b want %b", c, got, want);
            end
            if (c == 1) req = 1'b0;
        end
    endtask

    task automatic test_retarget();
        rst = 1'b1; req = 1'b0;
        tick(); tick();
        rst = 1'b0; des = 3'd5; req = 1'b1;
        for (int c = 1; c <= 4; c++) exp_q.push_back(ev(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 10'd0));
        exp_q.push_back(ev(3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000010, 10'b0000000100));
        for (int c = 6; c <= 7; c++) exp_q.push_back(ev(3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 10'd0));
        exp_q.push_back(ev(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 10'd0));
        for (int c = 1; c <= 8; c++) begin
            tick();
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL retarget c%0d: got %b want %b", c, got, want);
            end
            if (c == 1) des = 3'd2;
            if (c == 5) req = 1'b0;
        end
    endtask

    task automatic test_hold();
        des = 3'd2; req = 1'b1;
        exp_q.push_back(ev(3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000010, 10'b0000000110));
        for (int c = 2; c <= 8; c++) exp_q.push_back(ev(3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 10'd0));
        exp_q.push_back(ev(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 10'd0));
        for (int c = 1; c <= 9; c++) begin
            tick();
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL hold c%0d: got %b want %b", c, got, want);
            end
            if (c == 1) begin req = 1'b0; hold = 1'b1; end
            if (c == 6) hold = 1'b0;
        end
    endtask

    task automatic test_move_down();
        des = 3'd1; req = 1'b1;
        for (int c = 1; c <= 4; c++) exp_q.push_back(ev(3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 10'd0));
        exp_q.push_back(ev(3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 6'b000001, 10'b0000000001));
        for (int c = 6; c <= 7; c++) exp_q.push_back(ev(3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 10'd0));
        exp_q.push_back(ev(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 10'd0));
        for (int c = 1; c <= 8; c++) begin
            tick();
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL move_down c%0d: got %b want %b", c, got, want);
            end
            if (c == 5) req = 1'b0;
        end
    endtask

    task automatic test_invalid_req();
        des = 3'd7; req = 1'b1;
        for (int c = 1; c <= 4; c++) exp_q.push_back(ev(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 10'd0));
        for (int c = 1; c <= 4; c++) begin
            tick();
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL invalid_req c%0d: got %b want %b", c, got, want);
            end
            if (c == 2) des = 3'd0;
            if (c == 3) begin des = 3'd4; req = 1'b0; end
        end
    endtask

    task automatic test_reset_mid_move();
        des = 3'd6; req = 1'b1;
        for (int c = 1; c <= 4; c++) exp_q.push_back(ev(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 10'd0));
        for (int c = 5; c <= 8; c++) exp_q.push_back(ev(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 10'd0));
        for (int c = 9; c <= 12; c++) exp_q.push_back(ev(3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 10'd0));
        exp_q.push_back(ev(3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 10'd0));
        for (int c = 14; c <= 15; c++) exp_q.push_back(ev(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 10'd0));
        for (int c = 1; c <= 15; c++) begin
            tick();
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_mid_move c%0d: got %b want %b", c, got, want);
            end
            if (c == 13) begin rst = 1'b1; req = 1'b0; end
            if (c == 14) rst = 1'b0;
        end
    endtask

    initial begin
`ifdef CAR_ESTOP_EN
        estop = 1'b0;
`endif
        test_reset();
        test_move_up();
        test_door_here();
        test_retarget();
        test_hold();
        test_move_down();
        test_invalid_req();
        test_reset_mid_move();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
